// File: rtl/clkdiv_prog_if.sv
`default_nettype none
// ============================================================================
// Module   : clkdiv_prog_if
// Brief    : Divisor-write handshake bundle for clkdiv_prog
// Revision : 1.0
// ============================================================================
interface clkdiv_prog_if #(
    parameter int CH = 2,
    parameter int W  = 8
);
    localparam int c_CW = (CH > 1) ? $clog2(CH) : 1;

    logic            cfg_valid;
    logic [c_CW-1:0] cfg_ch;
    logic [W-1:0]    cfg_div;
    logic            cfg_ready;

    modport master (output cfg_valid, cfg_ch, cfg_div, input  cfg_ready);
    modport slave  (input  cfg_valid, cfg_ch, cfg_div, output cfg_ready);
endinterface
`default_nettype wire

// File: rtl/clkdiv_prog.sv
`default_nettype none
// ============================================================================
// Module   : clkdiv_prog
// Brief    : Multi-channel programmable clock-enable divider (strobe + level)
// Revision : 1.0
// ============================================================================
module clkdiv_prog #(
    parameter int CH       = 2,
    parameter int W        = 8,
    parameter int DIV_INIT = 5
) (
    input  wire           hclkin,
    input  wire           reset,
    input  wire  [CH-1:0] en,
    input  wire           sync,
    clkdiv_prog_if.slave  cfg,
    output logic [CH-1:0] stb,
    output logic [CH-1:0] clkout,
    output logic [CH-1:0] busy
);
    localparam int           c_CW       = (CH > 1) ? $clog2(CH) : 1;
    localparam int           c_PADW     = 1 << c_CW;
    localparam logic [W-1:0] c_DIV_INIT = W'(DIV_INIT);

    logic [CH-1:0]     w_pend;
    logic [c_PADW-1:0] w_pend_pad;

    // Unused channel indices read as "not pending", so writes to them complete and vanish.
    assign w_pend_pad    = c_PADW'(w_pend);
    assign cfg.cfg_ready = ~w_pend_pad[cfg.cfg_ch];

    generate
        for (genvar i = 0; i < CH; i++) begin : g_ch
            logic [W-1:0] r_cnt;
            logic [W-1:0] r_div;
            logic [W-1:0] r_pdiv;
            logic         r_pend;
            logic         r_stb;
            logic         r_clk;
            logic         w_run;
            logic         w_last;
            logic         w_apply;
            logic         w_wr;

            assign w_run   = en[i] && (r_div != '0);
            assign w_last  = (r_cnt == (r_div - W'(1)));
            assign w_apply = sync || (r_pend && (w_last || !w_run));
            assign w_wr    = cfg.cfg_valid && cfg.cfg_ready &&
                             (cfg.cfg_ch == c_CW'(i));

            always_ff @(posedge hclkin) begin
                if (reset) begin
                    r_cnt  <= '0;
                    r_div  <= c_DIV_INIT;
                    r_pdiv <= '0;
                    r_pend <= 1'b0;
                    r_stb  <= 1'b0;
                    r_clk  <= 1'b0;
                end else begin
                    // Outputs reflect the phase held during this cycle.
                    r_stb <= w_run && (r_cnt == '0);
                    r_clk <= w_run && (r_cnt < (r_div - (r_div >> 1)));

                    if (w_apply) begin
                        if (r_pend) begin
                            r_div <= r_pdiv;
                        end
                        r_cnt  <= '0;
                        r_pend <= 1'b0;
                    end else if (!w_run || w_last) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + W'(1);
                    end

                    // A write landing with sync/apply becomes the next pending value.
                    if (w_wr) begin
                        r_pdiv <= cfg.cfg_div;
                        r_pend <= 1'b1;
                    end
                end
            end

            assign w_pend[i] = r_pend;
            assign stb[i]    = r_stb;
            assign clkout[i] = r_clk;
            assign busy[i]   = r_pend;
        end
    endgenerate
endmodule
`default_nettype wire
